serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 71 +++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one bit per clock, with IDLE/ADD/FIN control
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;
  state_t           state;
  logic [WIDTH-1:0] ra, rb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             hx, s, c_next, last;
  assign hx     = ra[0] ^ rb[0];
  assign s      = hx ^ carry;
  assign c_next = (ra[0] & rb[0]) | (carry & hx);
  assign last   = cnt == CW'(WIDTH - 1);
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      COUT  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          state <= ADD;
          ra    <= A;
          rb    <= B;
          carry <= 1'b0;
          cnt   <= '0;
          SUM   <= '0;
          COUT  <= 1'b0;
          BUSY  <= 1'b1;
        end
        ADD: begin
          SUM   <= {s, SUM[WIDTH-1:1]};
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= c_next;
          // counter parks on the last bit so it never wraps inside an operation
          cnt   <= last ? cnt : cnt + 1'b1;
          if (last) begin
            state <= FIN;
            DONE  <= 1'b1;
            COUT  <= c_next;
          end
        end
        FIN: begin
          state <= IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
